pbch_re_demapper: RTL and testbench
===================================

# pbch_re_demapper

Downstream consumer of the post-FFT round/saturate stage. Takes the SSB resource grid as a stream of S0.15 I/Q samples (4 OFDM symbols × 240 subcarriers, symbol-major), discards PSS/SSS/guard REs and emits PBCH REs in order, each tagged as data or DM-RS according to the cell's `v = N_ID mod 4`. Output goes through a small FIFO with valid/ready so the channel estimator and equalizer can stall it.

## Interface
- `WORD_LENGTH`, 16: I/Q sample width, signed S0.15.
- `FIFO_DEPTH`, 16: output FIFO entries, power of two, ≥4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `i_in` input WORD_LENGTH: in-phase sample, signed.
- `q_in` input WORD_LENGTH: quadrature sample, signed.
- `in_valid` input 1: sample present.
- `in_ready` output 1: block can accept; a beat transfers when `in_valid && in_ready`.
- `in_ssb_start` input 1: qualifies the beat as SSB symbol 0, subcarrier 0.
- `cell_id_mod4` input 2: `v`, sampled on the accepted `in_ssb_start` beat.
- `i_out`, `q_out` output WORD_LENGTH: PBCH RE sample.
- `out_dmrs` output 1: 1 = DM-RS RE, 0 = PBCH data RE.
- `out_last` output 1: final PBCH RE of the SSB.
- `out_valid` output 1; `out_ready` input 1: output handshake.
- `ssb_done` output 1: one-cycle pulse, SSB fully consumed at input.
- `err_restart` output 1: sticky, SSB restarted before completion.

## Operation
- FSM states: IDLE, ACTIVE.
- IDLE: accepted beats without `in_ssb_start` are discarded. Accepted beat with `in_ssb_start` → ACTIVE, `sc=1`, `sym=0`, latch `v`.
- ACTIVE: each accepted beat has position (`sym`, `sc`). `sc` wraps 239→0 and increments `sym`. The beat at (3,239) returns to IDLE and fires `ssb_done`.
- PBCH region:
  - sym 1 and 3: all sc 0..239.
  - sym 2: sc 0..47 and 192..239.
  - sym 0: none.
- In-region RE → FIFO write of {i, q, dmrs = (sc mod 4 == v), last = (sym==3 && sc==239)}. All other REs are dropped.
- Per SSB: 432 data REs and 144 DM-RS REs, 576 writes total.
- `in_ssb_start` on an accepted beat in ACTIVE: restart at (0,0) with new `v` and set `err_restart`. That beat is itself at sym 0, so nothing is written. FIFO contents already written are kept; no `out_last` is generated for the aborted SSB.
- `in_ready = !fifo_full`. The PBCH write is the only FIFO producer, so a beat is never accepted without room.
- Samples pass bit-exact; no arithmetic.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 from the first cycle after release. All other outputs are 0: `out_valid`, `i_out`, `q_out`, `out_dmrs`, `out_last`, `ssb_done`, `err_restart`. FSM→IDLE, counters→0, FIFO empty.
- Reset mid-SSB discards FIFO contents and the partial SSB.
- Latency: beat accepted at edge n appears on `out_*` after edge n+1 when the FIFO is empty (first-word-fall-through).
- `out_*` are held stable while `out_valid && !out_ready`.
- Simultaneous FIFO read and write when full:
  - `in_ready` is computed from the registered count.
  - Full blocks input that cycle even if a read occurs.
  - Throughput is one beat/cycle when not full.
- `ssb_done` asserts the cycle after the (3,239) beat is accepted.

## Structure
- Shared package `mib_pkg`:
  - `SSB_NSC`=240, `SSB_NSYM`=4
  - `PBCH_SYM2_LO_END`=47, `PBCH_SYM2_HI_START`=192
  - `PBCH_DATA_RE`=432, `PBCH_DMRS_RE`=144
  - FSM state enum
- Sub-module `iq_sync_fifo`: single-clock FWFT FIFO, parameterised width/depth, `full`/`empty`/`count`, synchronous active-low reset. Used here at width 2·WORD_LENGTH+2.

## Test plan
- Full SSB, v=0, `out_ready`=1, input sample = (sym·240+sc) on both I and Q:
  - 576 outputs: 144 with `out_dmrs`=1, at sc 0,4,…,236 of sym 1/3 and sc 0..44, 192..236 of sym 2.
  - `out_last` only on sample 959.
  - `ssb_done` on the cycle after the final beat.
- v=3, same stimulus:
  - DM-RS at sc≡3 mod 4.
  - Last output sample 959 has `out_dmrs`=1, `out_last`=1.
- `out_ready`=0 throughout:
  - `in_ready` drops after exactly FIFO_DEPTH (16) PBCH writes.
  - Released later, all 576 outputs arrive in order with no loss or duplication.
- `in_ssb_start` at (2,100):
  - `err_restart` goes 1 and stays 1.
  - Counters restart; the following complete SSB yields exactly 576 outputs with one `out_last`.
- Beats with `in_valid`=1 but no `in_ssb_start` while IDLE: no outputs, `ssb_done` stays 0.
- `rst_n`=0 for one cycle mid-SSB with FIFO half full:
  - Next cycle all outputs 0, `out_valid`=0.
  - `in_ready`=1 one cycle after release.

Source files
------------

// File: rtl/mib_pkg.sv
// mib_pkg: SSB grid geometry, PBCH region helper and demapper FSM states.
package mib_pkg;
  localparam int SSB_NSC = 240;
  localparam int SSB_NSYM = 4;
  localparam int PBCH_SYM2_LO_END = 47;
  localparam int PBCH_SYM2_HI_START = 192;
  localparam int PBCH_DATA_RE = 432;
  localparam int PBCH_DMRS_RE = 144;
  typedef enum logic {IDLE, ACTIVE} state_t;
  // Symbols 1 and 3 are fully PBCH; symbol 2 only outside the SSS band.
  function automatic logic is_pbch(input logic [1:0] sym, input logic [7:0] sc);
    return sym[0] || (sym == 2'd2 && (sc <= 8'(PBCH_SYM2_LO_END) || sc >= 8'(PBCH_SYM2_HI_START)));
  endfunction
endpackage

// File: rtl/pbch_re_demapper_if.sv
// pbch_re_demapper_if: input sample stream, output PBCH RE stream and status.
interface pbch_re_demapper_if #(parameter int WORD_LENGTH = 16);
  logic signed [WORD_LENGTH-1:0] i_in, q_in, i_out, q_out;
  logic in_valid, in_ready, in_ssb_start;
  logic [1:0] cell_id_mod4;
  logic out_dmrs, out_last, out_valid, out_ready;
  logic ssb_done, err_restart;
  modport slave (
    input i_in, q_in, in_valid, in_ssb_start, cell_id_mod4, out_ready,
    output in_ready, i_out, q_out, out_dmrs, out_last, out_valid, ssb_done, err_restart
  );
  modport master (
    output i_in, q_in, in_valid, in_ssb_start, cell_id_mod4, out_ready,
    input in_ready, i_out, q_out, out_dmrs, out_last, out_valid, ssb_done, err_restart
  );
endinterface

// File: rtl/iq_sync_fifo.sv
// iq_sync_fifo: single-clock first-word-fall-through FIFO, reads as zero when empty.
module iq_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wr ? wp + AW'(1) : wp;
      rp <= rd ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/pbch_re_demapper.sv
// pbch_re_demapper: walks the SSB grid, keeps PBCH REs tagged data/DM-RS, buffers them in a FIFO.
module pbch_re_demapper import mib_pkg::*; #(
  parameter int WORD_LENGTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst_n,
  pbch_re_demapper_if.slave bus
);
  localparam int W = 2*WORD_LENGTH + 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic [1:0] sym, sym_nx, v, v_nx;
  logic [7:0] sc, sc_nx;
  logic acc, start, at_last, sc_wrap, in_pbch, done_nx, wr_q, full, empty;
  logic [W-1:0] wd_q, rd;
  logic [CW-1:0] count;
  assign acc = bus.in_valid && bus.in_ready;
  assign start = acc && bus.in_ssb_start;
  assign sc_wrap = sc == 8'(SSB_NSC-1);
  assign at_last = sym == 2'd3 && sc_wrap;
  assign in_pbch = acc && !bus.in_ssb_start && state == ACTIVE && is_pbch(sym, sc);
  // The staged write counts against capacity so the FIFO can never overflow.
  assign bus.in_ready = rst_n && !full && !(wr_q && count == CW'(FIFO_DEPTH-1));
  always_comb begin
    state_nx = state;
    sym_nx = sym;
    sc_nx = sc;
    v_nx = v;
    done_nx = 1'b0;
    if (start) begin
      state_nx = ACTIVE;
      sym_nx = 2'd0;
      sc_nx = 8'd1;
      v_nx = bus.cell_id_mod4;
    end else if (acc && state == ACTIVE) begin
      done_nx = at_last;
      state_nx = at_last ? IDLE : ACTIVE;
      sc_nx = sc_wrap ? 8'd0 : sc + 8'd1;
      sym_nx = sc_wrap ? sym + 2'd1 : sym;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sym <= '0;
      sc <= '0;
      v <= '0;
      wr_q <= 1'b0;
      wd_q <= '0;
      bus.ssb_done <= 1'b0;
      bus.err_restart <= 1'b0;
    end else begin
      state <= state_nx;
      sym <= sym_nx;
      sc <= sc_nx;
      v <= v_nx;
      wr_q <= in_pbch;
      wd_q <= {bus.i_in, bus.q_in, sc[1:0] == v, at_last};
      bus.ssb_done <= done_nx;
      bus.err_restart <= bus.err_restart || (start && state == ACTIVE);
    end
  end
  iq_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_q),
    .wr_data(wd_q),
    .rd_en(bus.out_ready),
    .rd_data(rd),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign {bus.i_out, bus.q_out, bus.out_dmrs, bus.out_last} = rd;
  assign bus.out_valid = !empty;
endmodule

// File: tb/tb_pbch_re_demapper.sv
// tb_pbch_re_demapper: directed SSB streams checked against a queue of expected PBCH REs.
module tb_pbch_re_demapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pbch_re_demapper_if #(.WORD_LENGTH(16)) bif ();
  pbch_re_demapper #(.WORD_LENGTH(16), .FIFO_DEPTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  int n_vec = 0, n_err = 0;
  int n_out = 0, n_dmrs = 0, n_last = 0, n_done = 0;
  logic last_dmrs = 1'b0;
  logic [33:0] exp_q[$];
  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit pb(input int sym, input int sc);
    return sym == 1 || sym == 3 || (sym == 2 && (sc < 48 || sc >= 192));
  endfunction
  // One beat at grid index k = sym*240+sc; trk enables the reference model.
  task automatic beat(input int k, input bit st, input logic [1:0] v, input bit trk);
    bif.in_valid = 1'b1;
    bif.in_ssb_start = st;
    bif.cell_id_mod4 = v;
    bif.i_in = 16'(k);
    bif.q_in = 16'(k);
    for (int t = 0; bif.in_ready !== 1'b1; t++) begin
      if (t == 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready_timeout observed=0 expected=1 at k=%0d", k);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
        return;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    bif.in_ssb_start = 1'b0;
    if (trk && !st && pb(k / 240, k % 240))
      exp_q.push_back({16'(k), 16'(k), 1'((k % 240) % 4 == int'(v)), 1'(k == 959)});
  endtask
  task automatic send(input int k0, input int k1, input logic [1:0] v);
    for (int k = k0; k <= k1; k++) beat(k, k == 0, v, 1'b1);
  endtask
  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    n_out = 0;
    n_dmrs = 0;
    n_last = 0;
    n_done = 0;
  endtask
  always @(negedge clk) begin
    if (rst_n && bif.ssb_done) n_done++;
    if (rst_n && bif.out_valid && bif.out_ready) begin
      n_out++;
      n_dmrs += int'(bif.out_dmrs);
      n_last += int'(bif.out_last);
      if (bif.out_last) last_dmrs = bif.out_dmrs;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL out_extra observed=%0h expected=none", {bif.i_out, bif.q_out, bif.out_dmrs, bif.out_last});
      end else
        check("out_re", {bif.i_out, bif.q_out, bif.out_dmrs, bif.out_last}, exp_q.pop_front());
    end
  end
  initial begin
    bif.in_valid = 1'b0;
    bif.in_ssb_start = 1'b0;
    bif.cell_id_mod4 = 2'd0;
    bif.i_in = '0;
    bif.q_in = '0;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 34'(bif.in_ready), 34'd0);
    check("rst_out_valid", 34'(bif.out_valid), 34'd0);
    check("rst_out_word", {bif.i_out, bif.q_out, bif.out_dmrs, bif.out_last}, 34'd0);
    check("rst_flags", {32'd0, bif.ssb_done, bif.err_restart}, 34'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 34'(bif.in_ready), 34'd1);
    // v=0 full SSB, with a first-word-fall-through latency probe on the first PBCH RE
    clr();
    send(0, 239, 2'd0);
    beat(240, 1'b0, 2'd0, 1'b1);
    check("fwft_not_yet", 34'(bif.out_valid), 34'd0);
    @(posedge clk);
    #1;
    check("fwft_valid", 34'(bif.out_valid), 34'd1);
    check("fwft_word", {bif.i_out, bif.q_out, bif.out_dmrs, bif.out_last}, {16'd240, 16'd240, 1'b1, 1'b0});
    send(241, 958, 2'd0);
    beat(959, 1'b0, 2'd0, 1'b1);
    check("v0_done_pulse", 34'(bif.ssb_done), 34'd1);
    @(posedge clk);
    #1;
    check("v0_done_clear", 34'(bif.ssb_done), 34'd0);
    drain();
    check("v0_n_out", 34'(n_out), 34'd576);
    check("v0_n_dmrs", 34'(n_dmrs), 34'd144);
    check("v0_n_last", 34'(n_last), 34'd1);
    check("v0_n_done", 34'(n_done), 34'd1);
    check("v0_pending", 34'(exp_q.size()), 34'd0);
    // v=3: the final RE sits at sc 239 = 3 mod 4, so it is DM-RS
    clr();
    send(0, 959, 2'd3);
    drain();
    check("v3_n_out", 34'(n_out), 34'd576);
    check("v3_n_dmrs", 34'(n_dmrs), 34'd144);
    check("v3_n_last", 34'(n_last), 34'd1);
    check("v3_last_dmrs", 34'(last_dmrs), 34'd1);
    // beats while IDLE without start are discarded
    clr();
    for (int k = 300; k < 320; k++) beat(k, 1'b0, 2'd0, 1'b0);
    drain();
    check("idle_n_out", 34'(n_out), 34'd0);
    check("idle_n_done", 34'(n_done), 34'd0);
    check("idle_out_valid", 34'(bif.out_valid), 34'd0);
    // backpressure: sym 0 writes nothing, so (1,15) is the 16th PBCH write
    clr();
    bif.out_ready = 1'b0;
    send(0, 254, 2'd1);
    check("bp_ready_15", 34'(bif.in_ready), 34'd1);
    beat(255, 1'b0, 2'd1, 1'b1);
    check("bp_ready_16", 34'(bif.in_ready), 34'd0);
    repeat (10) @(posedge clk);
    #1;
    check("bp_still_full", 34'(bif.in_ready), 34'd0);
    check("bp_head_held", {bif.i_out, bif.q_out, bif.out_dmrs, bif.out_last}, {16'd240, 16'd240, 1'b0, 1'b0});
    bif.out_ready = 1'b1;
    send(256, 959, 2'd1);
    drain();
    check("bp_n_out", 34'(n_out), 34'd576);
    check("bp_n_last", 34'(n_last), 34'd1);
    check("bp_pending", 34'(exp_q.size()), 34'd0);
    // restart at (2,100): partial SSB keeps its 288 REs, then a full SSB follows
    clr();
    send(0, 579, 2'd1);
    send(0, 959, 2'd2);
    drain();
    check("abort_err", 34'(bif.err_restart), 34'd1);
    check("abort_n_out", 34'(n_out), 34'd864);
    check("abort_n_last", 34'(n_last), 34'd1);
    check("abort_n_done", 34'(n_done), 34'd1);
    check("abort_pending", 34'(exp_q.size()), 34'd0);
    drain();
    check("abort_err_sticky", 34'(bif.err_restart), 34'd1);
    // one-cycle reset with the FIFO half full
    bif.out_ready = 1'b0;
    send(0, 247, 2'd0);
    check("mid_valid", 34'(bif.out_valid), 34'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 34'(bif.in_ready), 34'd0);
    @(posedge clk);
    #1;
    check("mid_rst_valid", 34'(bif.out_valid), 34'd0);
    check("mid_rst_word", {bif.i_out, bif.q_out, bif.out_dmrs, bif.out_last}, 34'd0);
    check("mid_rst_flags", {32'd0, bif.ssb_done, bif.err_restart}, 34'd0);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", 34'(bif.in_ready), 34'd1);
    check("mid_rel_valid", 34'(bif.out_valid), 34'd0);
    bif.out_ready = 1'b1;
    clr();
    send(0, 959, 2'd2);
    drain();
    check("recov_n_out", 34'(n_out), 34'd576);
    check("recov_n_last", 34'(n_last), 34'd1);
    check("recov_pending", 34'(exp_q.size()), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
